// File: rtl/status_hit_resolver_pkg.sv
// Types and helpers shared by the hit resolver and its victim selector.
`include "status_array_params.vh"

package status_hit_resolver_pkg;

    localparam int NUM_BLOCKS = `SA_NUM_BLOCKS;
    localparam int ADDR_WIDTH = `SA_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = `SA_ST_IDLE,
        ST_MISS_WAIT = `SA_ST_MISS_WAIT,
        ST_UPDATE    = `SA_ST_UPDATE
    } state_e;

    // Isolates the lowest set bit, giving lowest-index-wins priority.
    function automatic logic [NUM_BLOCKS-1:0] lowest_one(input logic [NUM_BLOCKS-1:0] v);
        return v & (~v + NUM_BLOCKS'(1));
    endfunction

    function automatic logic [NUM_BLOCKS-1:0] rotl1(input logic [NUM_BLOCKS-1:0] v);
        return {v[NUM_BLOCKS-2:0], v[NUM_BLOCKS-1]};
    endfunction

endpackage

// File: rtl/status_array_params.vh
// Shared status-array geometry and resolver state encodings.
// Included by every file that needs the slot layout or the FSM codes.
`ifndef STATUS_ARRAY_PARAMS_VH
`define STATUS_ARRAY_PARAMS_VH

`define SA_NUM_BLOCKS        4
`define SA_ADDR_WIDTH        6
`define SA_ROW_WIDTH(tw)     (`SA_NUM_BLOCKS * ((tw) + 1))

`define SA_ST_IDLE           2'd0
`define SA_ST_MISS_WAIT      2'd1
`define SA_ST_UPDATE         2'd2

`endif

// File: rtl/status_hit_resolver_victim_selector.sv
// Miss victim choice: lowest invalid slot first, round-robin pointer when the set is full.
`include "status_array_params.vh"

module victim_selector
    import status_hit_resolver_pkg::*;
(
    input  logic [NUM_BLOCKS-1:0] valid_i,
    input  logic [NUM_BLOCKS-1:0] rr_ptr_i,
    output logic [NUM_BLOCKS-1:0] victim_o,
    output logic                  from_rr_o
);

    always_comb begin
        victim_o  = '0;
        from_rr_o = 1'b0;
        if (&valid_i) begin
            victim_o  = rr_ptr_i;
            from_rr_o = 1'b1;
        end else begin
            victim_o  = lowest_one(~valid_i);
        end
    end

endmodule

// File: rtl/status_hit_resolver.sv
// Resolves status-array lookups into hit/miss, tracks one pending miss and
// writes the refilled slot back into the status array.
//   state     | meaning
//   IDLE      | ready for a lookup
//   MISS_WAIT | miss outstanding, waiting for the refill to finish
//   UPDATE    | one-cycle status write of the refilled slot
`include "status_array_params.vh"

module status_hit_resolver
    import status_hit_resolver_pkg::*;
#(
    parameter  int TAG_WIDTH = 1,
    localparam int ROW_WIDTH = `SA_ROW_WIDTH(TAG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_halt,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ROW_WIDTH-1:0]  i_data,
    input  logic                  i_valid,
    input  logic                  i_fill_done,
    output logic                  o_valid,
    output logic                  o_hit,
    output logic [NUM_BLOCKS-1:0] o_way,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ROW_WIDTH-1:0]  o_w_data,
    output logic [NUM_BLOCKS-1:0] o_w_wmask,
    output logic                  o_w_valid
);

    localparam int SLOT_W = TAG_WIDTH + 1;

    state_e                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   rr_q, rr_d;

    logic                    valid_q;
    logic                    hit_q;
    logic [NUM_BLOCKS-1:0]   way_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic [TAG_WIDTH-1:0]    miss_tag_q;
    logic [ADDR_WIDTH-1:0]   miss_addr_q;
    logic [NUM_BLOCKS-1:0]   miss_way_q;
    logic                    miss_rr_q;

    logic [NUM_BLOCKS-1:0]   slot_valid;
    logic [NUM_BLOCKS-1:0]   slot_match;
    logic [NUM_BLOCKS-1:0]   hit_way;
    logic [NUM_BLOCKS-1:0]   victim;
    logic                    victim_from_rr;
    logic                    hit;
    logic                    accept;
    logic                    in_update;

    always_comb begin
        slot_valid = '0;
        slot_match = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            slot_valid[k] = i_data[k*SLOT_W + TAG_WIDTH];
            slot_match[k] = slot_valid[k] && (i_data[k*SLOT_W +: TAG_WIDTH] == i_tag);
        end
    end

    assign hit     = |slot_match;
    assign hit_way = lowest_one(slot_match);

    victim_selector u_victim_selector (
        .valid_i   (slot_valid),
        .rr_ptr_i  (rr_q),
        .victim_o  (victim),
        .from_rr_o (victim_from_rr)
    );

    assign o_ready = (state_q == ST_IDLE) && !srst;
    assign accept  = i_valid && o_ready && !i_halt;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !hit) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (i_fill_done && !i_halt) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (!i_halt) begin
                    state_d = ST_IDLE;
                    if (miss_rr_q) rr_d = rotl1(rr_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            rr_q        <= NUM_BLOCKS'(1);
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            miss_tag_q  <= '0;
            miss_addr_q <= '0;
            miss_way_q  <= '0;
            miss_rr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            // Result valid is a pulse: a halt never stretches it.
            valid_q <= accept;
            if (accept) begin
                hit_q  <= hit;
                way_q  <= hit ? hit_way : victim;
                tag_q  <= i_tag;
                addr_q <= i_addr;
                if (!hit) begin
                    miss_tag_q  <= i_tag;
                    miss_addr_q <= i_addr;
                    miss_way_q  <= victim;
                    miss_rr_q   <= victim_from_rr;
                end
            end
        end
    end

    assign o_valid = valid_q;
    assign o_hit   = hit_q;
    assign o_way   = way_q;
    assign o_tag   = tag_q;
    assign o_addr  = addr_q;

    // Write row carries the new entry in every slot; the mask picks the victim.
    assign in_update = (state_q == ST_UPDATE) && !srst;
    assign o_w_valid = in_update && !i_halt;
    assign o_w_addr  = in_update ? miss_addr_q : '0;
    assign o_w_wmask = in_update ? miss_way_q : '0;
    assign o_w_data  = in_update ? {NUM_BLOCKS{{1'b1, miss_tag_q}}} : '0;

endmodule

// File: tb/tb_status_hit_resolver.sv
// Scoreboard bench for status_hit_resolver: directed scenarios plus random
// lookups checked against a slot-level reference model.
`include "status_array_params.vh"

module tb_status_hit_resolver;
    import status_hit_resolver_pkg::*;

    localparam int TW = 4;
    localparam int NB = NUM_BLOCKS;
    localparam int AW = ADDR_WIDTH;
    localparam int RW = NB * (TW + 1);

    logic          clk = 1'b0;
    logic          srst;
    logic          i_halt;
    logic [TW-1:0] i_tag;
    logic [AW-1:0] i_addr;
    logic [RW-1:0] i_data;
    logic          i_valid;
    logic          i_fill_done;
    logic          o_valid;
    logic          o_hit;
    logic [NB-1:0] o_way;
    logic [TW-1:0] o_tag;
    logic [AW-1:0] o_addr;
    logic          o_ready;
    logic [AW-1:0] o_w_addr;
    logic [RW-1:0] o_w_data;
    logic [NB-1:0] o_w_wmask;
    logic          o_w_valid;

    status_hit_resolver #(.TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .srst        (srst),
        .i_halt      (i_halt),
        .i_tag       (i_tag),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_fill_done (i_fill_done),
        .o_valid     (o_valid),
        .o_hit       (o_hit),
        .o_way       (o_way),
        .o_tag       (o_tag),
        .o_addr      (o_addr),
        .o_ready     (o_ready),
        .o_w_addr    (o_w_addr),
        .o_w_data    (o_w_data),
        .o_w_wmask   (o_w_wmask),
        .o_w_valid   (o_w_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hit;
        logic [NB-1:0] way;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
    } res_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [NB-1:0] mask;
        logic [RW-1:0] data;
    } wr_t;

    res_t exp_q[$];
    wr_t  wexp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: round-robin index and the one outstanding miss.
    int            rr_idx;
    bit            pend;
    int            pend_victim;
    bit            pend_rr;
    logic [TW-1:0] pend_tag;
    logic [AW-1:0] pend_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] slot(input int k, input bit v, input logic [TW-1:0] t);
        logic [RW-1:0] r;
        r = '0;
        r[k*(TW+1) +: TW+1] = {v, t};
        return r;
    endfunction

    task automatic lookup(input logic [RW-1:0] row, input logic [TW-1:0] tag, input logic [AW-1:0] addr);
        res_t e;
        int   hit_k;
        int   inv_k;
        int   vic;
        bit   v;
        logic [TW-1:0] t;
        hit_k = -1;
        inv_k = -1;
        for (int k = 0; k < NB; k++) begin
            v = row[k*(TW+1) + TW];
            t = row[k*(TW+1) +: TW];
            if (v && t == tag && hit_k < 0) hit_k = k;
            if (!v && inv_k < 0) inv_k = k;
        end
        e.tag  = tag;
        e.addr = addr;
        e.hit  = (hit_k >= 0);
        e.way  = '0;
        if (hit_k >= 0) begin
            e.way[hit_k] = 1'b1;
        end else begin
            vic = (inv_k >= 0) ? inv_k : rr_idx;
            e.way[vic]  = 1'b1;
            pend        = 1'b1;
            pend_victim = vic;
            pend_rr     = (inv_k < 0);
            pend_tag    = tag;
            pend_addr   = addr;
        end
        exp_q.push_back(e);
        check("ready_before_lookup", 64'(o_ready), 64'd1);
        i_data  = row;
        i_tag   = tag;
        i_addr  = addr;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("ready_after_lookup", 64'(o_ready), 64'(e.hit));
    endtask

    // Pulses i_fill_done; when it completes a pending miss, steps through UPDATE.
    task automatic fill(input bit halt);
        wr_t w;
        bit  wrote;
        wrote = 1'b0;
        i_fill_done = 1'b1;
        i_halt      = halt;
        tick();
        i_fill_done = 1'b0;
        i_halt      = 1'b0;
        if (!halt && pend) begin
            w.addr = pend_addr;
            w.mask = '0;
            w.mask[pend_victim] = 1'b1;
            for (int k = 0; k < NB; k++) w.data[k*(TW+1) +: TW+1] = {1'b1, pend_tag};
            wexp_q.push_back(w);
            if (pend_rr) rr_idx = (rr_idx + 1) % NB;
            pend  = 1'b0;
            wrote = 1'b1;
        end
        if (wrote) begin
            check("ready_in_update", 64'(o_ready), 64'd0);
            tick();
            check("ready_after_update", 64'(o_ready), 64'd1);
        end else begin
            check("ready_after_idle_fill", 64'(o_ready), 64'(!pend));
        end
    endtask

    res_t mon_r;
    wr_t  mon_w;

    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: o_valid=1, required 0 (no lookup outstanding)");
            end else begin
                mon_r = exp_q.pop_front();
                check("result_hit",  64'(o_hit),  64'(mon_r.hit));
                check("result_way",  64'(o_way),  64'(mon_r.way));
                check("result_tag",  64'(o_tag),  64'(mon_r.tag));
                check("result_addr", 64'(o_addr), 64'(mon_r.addr));
            end
        end
        if (o_w_valid) begin
            if (wexp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: o_w_valid=1, required 0");
            end else begin
                mon_w = wexp_q.pop_front();
                check("write_addr", 64'(o_w_addr),  64'(mon_w.addr));
                check("write_mask", 64'(o_w_wmask), 64'(mon_w.mask));
                check("write_data", 64'(o_w_data),  64'(mon_w.data));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   64'(o_valid),   64'd0);
        check({tag, "_hit"},     64'(o_hit),     64'd0);
        check({tag, "_way"},     64'(o_way),     64'd0);
        check({tag, "_tag"},     64'(o_tag),     64'd0);
        check({tag, "_addr"},    64'(o_addr),    64'd0);
        check({tag, "_ready"},   64'(o_ready),   64'd0);
        check({tag, "_wvalid"},  64'(o_w_valid), 64'd0);
        check({tag, "_waddr"},   64'(o_w_addr),  64'd0);
        check({tag, "_wmask"},   64'(o_w_wmask), 64'd0);
        check({tag, "_wdata"},   64'(o_w_data),  64'd0);
    endtask

    logic [RW-1:0] full_row;
    logic [RW-1:0] rrow;
    logic [TW-1:0] rtag;

    initial begin
        srst        = 1'b1;
        i_halt      = 1'b0;
        i_tag       = '0;
        i_addr      = '0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_fill_done = 1'b0;
        rr_idx      = 0;
        pend        = 1'b0;
        pend_victim = 0;
        pend_rr     = 1'b0;
        pend_tag    = '0;
        pend_addr   = '0;
        full_row    = slot(0, 1, 4'h1) | slot(1, 1, 4'h2) | slot(2, 1, 4'h3) | slot(3, 1, 4'h4);

        // Reset held two cycles, with halt asserted to show reset wins.
        i_halt = 1'b1;
        tick();
        check_all_zero("reset_c1");
        tick();
        check_all_zero("reset_c2");
        srst   = 1'b0;
        i_halt = 1'b0;
        #1;
        check("ready_after_reset", 64'(o_ready), 64'd1);

        // Hit in slot 2.
        lookup(slot(2, 1, 4'hA), 4'hA, 6'd5);
        check("hit_way_0100", 64'(o_way), 64'b0100);
        check("hit_flag", 64'(o_hit), 64'd1);
        check("hit_addr", 64'(o_addr), 64'd5);

        // Miss into first invalid slot, refill three cycles later.
        lookup(slot(0, 1, 4'h1) | slot(1, 1, 4'h2), 4'h7, 6'd5);
        check("miss_way_0100", 64'(o_way), 64'b0100);
        check("miss_flag", 64'(o_hit), 64'd0);
        tick();
        tick();
        i_fill_done = 1'b1;
        tick();
        i_fill_done = 1'b0;
        wexp_q.push_back('{addr: 6'd5, mask: 4'b0100, data: {NB{5'h17}}});
        pend = 1'b0;
        check("fill_wvalid", 64'(o_w_valid), 64'd1);
        check("fill_waddr", 64'(o_w_addr), 64'd5);
        check("fill_wmask", 64'(o_w_wmask), 64'b0100);
        check("fill_slot2", 64'(o_w_data[10 +: 5]), 64'h17);
        tick();
        check("ready_after_fill", 64'(o_ready), 64'd1);

        // Two full-set misses walk the round-robin pointer.
        lookup(full_row, 4'h9, 6'd1);
        check("rr_victim_0001", 64'(o_way), 64'b0001);
        fill(1'b0);
        lookup(full_row, 4'h9, 6'd2);
        check("rr_victim_0010", 64'(o_way), 64'b0010);
        fill(1'b0);

        // Halted refill is ignored; the next unhalted one completes.
        lookup(full_row, 4'hB, 6'd3);
        check("rr_victim_0100", 64'(o_way), 64'b0100);
        tick();
        fill(1'b1);
        check("halt_fill_wvalid", 64'(o_w_valid), 64'd0);
        tick();
        fill(1'b0);

        // Reset lands while UPDATE is active.
        lookup(full_row, 4'hC, 6'd4);
        check("rr_victim_1000", 64'(o_way), 64'b1000);
        i_fill_done = 1'b1;
        tick();
        i_fill_done = 1'b0;
        srst = 1'b1;
        #1;
        check("update_reset_wvalid_now", 64'(o_w_valid), 64'd0);
        tick();
        check("update_reset_wvalid", 64'(o_w_valid), 64'd0);
        check("update_reset_ready", 64'(o_ready), 64'd0);
        srst   = 1'b0;
        pend   = 1'b0;
        rr_idx = 0;
        #1;
        check("update_reset_release_ready", 64'(o_ready), 64'd1);
        lookup(full_row, 4'hD, 6'd7);
        check("rr_after_reset_0001", 64'(o_way), 64'b0001);
        fill(1'b0);

        // Random lookups with stray inputs and halts mixed in.
        for (int it = 0; it < 150; it++) begin
            rrow = '0;
            for (int k = 0; k < NB; k++)
                rrow |= slot(k, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)));
            rtag = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                i_halt  = 1'b1;
                i_valid = ($urandom_range(0, 1) == 1);
                tick();
                i_halt  = 1'b0;
                i_valid = 1'b0;
            end
            lookup(rrow, rtag, 6'($urandom));
            if (pend) begin
                for (int n = $urandom_range(0, 3); n > 0; n--) begin
                    case ($urandom_range(0, 2))
                        0: tick();
                        1: begin
                            i_data  = 20'($urandom);
                            i_tag   = 4'($urandom);
                            i_valid = 1'b1;
                            tick();
                            i_valid = 1'b0;
                        end
                        default: fill(1'b1);
                    endcase
                end
                fill(1'b0);
            end else if ($urandom_range(0, 3) == 0) begin
                fill(1'b0);
            end
        end

        tick();
        tick();
        check("results_drained", 64'(exp_q.size()), 64'd0);
        check("writes_drained", 64'(wexp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_hit_resolver.md
STATUS_HIT_RESOLVER -- requirements
Module: status_hit_resolver

Interface
REQ-001 SHALL have parameter: TAG_WIDTH, default 1, tag bits per status slot.
REQ-002 SHALL take NUM_BLOCKS, ADDR_WIDTH and ROW_WIDTH from status_array_params.vh, with ROW_WIDTH = NUM_BLOCKS*(TAG_WIDTH+1); slot k = bits [k*(TAG_WIDTH+1) +: TAG_WIDTH+1], {valid, tag}, valid in MSB.
REQ-003 SHALL have one clock and a synchronous, active-high reset, ports as follows:
  clk  in  1  single clock, rising edge.
  srst  in  1  synchronous active-high reset.
  i_halt  in  1  global stall; freezes all state.
  i_tag  in  TAG_WIDTH  lookup tag, from status array o_tag.
  i_addr  in  ADDR_WIDTH  set index carried with the lookup.
  i_data  in  ROW_WIDTH  status row, from status array o_data.
  i_valid  in  1  lookup valid, from status array o_valid.
  i_fill_done  in  1  one-cycle pulse: refill of the pending miss is complete.
  o_valid  out  1  lookup result valid, one-cycle pulse.
  o_hit  out  1  1 = hit, 0 = miss.
  o_way  out  NUM_BLOCKS  one-hot way: hit way, or victim way on a miss.
  o_tag  out  TAG_WIDTH  registered lookup tag.
  o_addr  out  ADDR_WIDTH  registered set index.
  o_ready  out  1  block can accept a lookup.
  o_w_addr  out  ADDR_WIDTH  status write address, to status array i_w_addr.
  o_w_data  out  ROW_WIDTH  status write row.
  o_w_wmask  out  NUM_BLOCKS  status write slot mask.
  o_w_valid  out  1  status write strobe.

Function
REQ-004 SHALL accept a lookup when i_valid & o_ready & ~i_halt.
REQ-005 SHALL drive o_valid, o_hit, o_way, o_tag and o_addr exactly one cycle after acceptance; o_valid SHALL be 0 in every other cycle.
REQ-006 SHALL declare a hit when any slot has valid=1 and tag==i_tag. o_way SHALL be that slot one-hot; if several slots match, the lowest index wins.
REQ-007 SHALL, on a miss, pick the victim as the lowest-index invalid slot; if all slots are valid, the victim is the slot named by the one-hot round-robin pointer rr_ptr.
REQ-008 SHALL implement the FSM IDLE, MISS_WAIT, UPDATE:
  IDLE -> MISS_WAIT on an accepted miss.
  IDLE -> IDLE on a hit.
  MISS_WAIT -> UPDATE on i_fill_done & ~i_halt.
  UPDATE -> IDLE after exactly one cycle.
REQ-009 SHALL drive o_ready=1 only in IDLE with srst=0.
REQ-010 SHALL, in UPDATE only, drive o_w_valid=1, o_w_addr=saved set, o_w_wmask=victim one-hot, and o_w_data={1'b1, saved tag} replicated into every slot.
REQ-011 SHALL hold o_w_valid=0 in IDLE and MISS_WAIT.
REQ-012 SHALL rotate rr_ptr left by one (wrapping MSB to bit 0) in UPDATE only when the victim came from rr_ptr.
REQ-013 SHALL, while i_halt=1, hold state, rr_ptr and all output registers, force o_w_valid=0, and ignore i_fill_done.
REQ-014 SHALL ignore i_valid and i_fill_done when they arrive outside the state in which they are meaningful.

Reset
REQ-015 SHALL, while srst=1, clear every output register to 0 (o_ready=0 included), set state to IDLE, set rr_ptr to one-hot slot 0, and discard any pending miss.
REQ-016 SHALL give srst priority over i_halt and over every other event, including reset arriving in MISS_WAIT or UPDATE.
REQ-017 SHALL drive o_ready=1 in the first cycle after srst deasserts.

Structure
REQ-018 SHALL keep NUM_BLOCKS, ADDR_WIDTH, ROW_WIDTH and the FSM state encodings in status_array_params.vh.
REQ-019 SHALL place victim choice (invalid-first priority plus rr_ptr fallback) in one sub-module, victim_selector.

Verification (TAG_WIDTH=4, NUM_BLOCKS=4)
REQ-020 Reset: srst=1 for 2 cycles -> all outputs 0 during reset; o_ready=1 in the first cycle after release.
REQ-021 Hit: slot2={1,0xA}, i_tag=0xA, i_addr=5 -> next cycle o_valid=1, o_hit=1, o_way=4'b0100, o_addr=5; o_ready stays 1.
REQ-022 Miss into invalid slot: slots 0 and 1 valid (tags 1, 2), slots 2 and 3 invalid, i_tag=7, i_addr=5 -> o_hit=0, o_way=4'b0100, o_ready=0. Then i_fill_done 3 cycles later -> one cycle of o_w_valid=1, o_w_addr=5, o_w_wmask=4'b0100, slot2 of o_w_data={1,7}; o_ready=1 the following cycle.
REQ-023 Round-robin: two consecutive all-valid misses, each completed by a fill -> victims 4'b0001 then 4'b0010.
REQ-024 Halt: i_halt=1 in MISS_WAIT while i_fill_done pulses -> state remains MISS_WAIT and o_w_valid=0; a later fill pulse with i_halt=0 -> UPDATE.
REQ-025 Reset mid-update: srst=1 in UPDATE -> o_w_valid=0 next cycle, state IDLE, rr_ptr=4'b0001.
